conn_bus_arbiter: RTL and testbench

Round-robin arbiter and burst sequencer that shares the single 32-bit data field of the 90-pin backplane connector between up to four on-board requesters. It grants the connector bus to one requester at a time and moves that requester's burst of words onto the connector pins with a strobe. It also controls the pin output enable and inserts a turnaround cycle between owners, so the bidirectional connector pins never see contention. It sits between the board-side data sources and the connector pad drivers.

---
 rtl/conn_bus_arbiter.sv | 173 +++++++++++++++++
 tb/tb_conn_bus_arbiter.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/conn_bus_arbiter.sv
// Round-robin owner of the connector data field: grants one requester, streams its burst, then turns the pins around.
// Optional stall abort is built when CONN_ARB_TIMEOUT_EN is defined.
module conn_bus_arbiter #(
   parameter int NREQ      = 4,
   parameter int DW        = 32,
   parameter int TO_CYCLES = 255
) (
   input  logic                 CLK,
   input  logic                 RESET,
   input  logic [NREQ-1:0]      REQ,
   input  logic [4*NREQ-1:0]    LEN,
   input  logic [DW*NREQ-1:0]   DIN,
   input  logic [NREQ-1:0]      VALID,
   output logic [NREQ-1:0]      READY,
   output logic [NREQ-1:0]      GNT,
   output logic [DW-1:0]        BUS_OUT,
   output logic                 BUS_OE,
   output logic                 BUS_STB,
   output logic                 DONE,
   output logic                 TIMEOUT_ERR
);

   localparam int IW = (NREQ > 2) ? 2 : 1;

   typedef enum logic [1:0] {IDLE, XFER, TURN} state_t;

   state_t            state_q, state_d;
   logic [IW-1:0]     last_q, last_d;
   logic [IW-1:0]     win_q, win_d;
   logic [3:0]        cnt_q, cnt_d;
   logic [NREQ-1:0]   gnt_q, gnt_d;
   logic              oe_q, oe_d;
   logic              stb_q, stb_d;
   logic [DW-1:0]     bus_q, bus_d;
   logic              done_q, done_d;

   logic [DW-1:0]     din_a [NREQ];
   logic [3:0]        len_a [NREQ];
   logic              found;
   logic [IW-1:0]     pick;
   logic              acc;
   logic              to_hit;

   for (genvar g = 0; g < NREQ; g++) begin : g_unpack
      assign din_a[g] = DIN[g*DW +: DW];
      assign len_a[g] = LEN[g*4 +: 4];
   end

   // Search begins one past the previous owner so every requester gets a turn.
   always_comb begin
      found = 1'b0;
      pick  = last_q;
      for (int i = 1; i <= NREQ; i++) begin
         logic [IW-1:0] cand;
         cand = IW'((int'(last_q) + i) % NREQ);
         if (!found && REQ[cand]) begin
            found = 1'b1;
            pick  = cand;
         end
      end
   end

   assign acc = (state_q == XFER) && VALID[win_q];

`ifdef CONN_ARB_TIMEOUT_EN
   logic [7:0] stall_q, stall_d;
   logic       terr_q;

   assign to_hit  = (state_q == XFER) && !acc && (stall_q == 8'(TO_CYCLES - 1));
   assign stall_d = ((state_q == XFER) && !acc) ? stall_q + 8'd1 : 8'd0;

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         stall_q <= 8'd0;
         terr_q  <= 1'b0;
      end else begin
         stall_q <= stall_d;
         if (to_hit) terr_q <= 1'b1;
      end
   end

   assign TIMEOUT_ERR = terr_q;
`else
   logic unused_to;
   assign unused_to   = ^8'(TO_CYCLES);
   assign to_hit      = 1'b0;
   assign TIMEOUT_ERR = 1'b0;
`endif

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         state_q <= IDLE;
         last_q  <= IW'(NREQ - 1);
         win_q   <= '0;
         cnt_q   <= '0;
         gnt_q   <= '0;
         oe_q    <= 1'b0;
         stb_q   <= 1'b0;
         bus_q   <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         last_q  <= last_d;
         win_q   <= win_d;
         cnt_q   <= cnt_d;
         gnt_q   <= gnt_d;
         oe_q    <= oe_d;
         stb_q   <= stb_d;
         bus_q   <= bus_d;
         done_q  <= done_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (found) state_d = XFER;
         XFER:    if ((acc && cnt_q == 4'd0) || to_hit) state_d = TURN;
         TURN:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      last_d = last_q;
      win_d  = win_q;
      cnt_d  = cnt_q;
      gnt_d  = gnt_q;
      oe_d   = oe_q;
      stb_d  = 1'b0;
      bus_d  = bus_q;
      done_d = 1'b0;
      case (state_q)
         IDLE: begin
            if (found) begin
               gnt_d = NREQ'(1) << pick;
               oe_d  = 1'b1;
               win_d = pick;
               cnt_d = len_a[pick];
            end
         end
         XFER: begin
            if (acc) begin
               bus_d = din_a[win_q];
               stb_d = 1'b1;
               cnt_d = cnt_q - 4'd1;
               if (cnt_q == 4'd0) begin
                  gnt_d  = '0;
                  last_d = win_q;
                  done_d = 1'b1;
               end
            end else if (to_hit) begin
               // Abort keeps the pins driven through TURN but flags no DONE.
               gnt_d  = '0;
               last_d = win_q;
            end
         end
         TURN: oe_d = 1'b0;
         default: begin
            gnt_d = '0;
            oe_d  = 1'b0;
         end
      endcase
   end

   assign GNT     = gnt_q;
   assign READY   = gnt_q;
   assign BUS_OE  = oe_q;
   assign BUS_STB = stb_q;
   assign BUS_OUT = bus_q;
   assign DONE    = done_q;

endmodule

// File: tb/tb_conn_bus_arbiter.sv
// Directed bench for conn_bus_arbiter: single bursts, stalls, round-robin order, reset abort and TURN-time requests.
module tb_conn_bus_arbiter;
   localparam int NREQ = 4;
   localparam int DW   = 32;

   logic                CLK = 1'b0;
   logic                RESET;
   logic [NREQ-1:0]     REQ;
   logic [4*NREQ-1:0]   LEN;
   logic [DW*NREQ-1:0]  DIN;
   logic [NREQ-1:0]     VALID;
   logic [NREQ-1:0]     READY, GNT;
   logic [DW-1:0]       BUS_OUT;
   logic                BUS_OE, BUS_STB, DONE, TIMEOUT_ERR;

   int n_chk = 0;
   int n_err = 0;

   conn_bus_arbiter #(.NREQ(NREQ), .DW(DW), .TO_CYCLES(4)) dut (
      .CLK(CLK), .RESET(RESET), .REQ(REQ), .LEN(LEN), .DIN(DIN), .VALID(VALID),
      .READY(READY), .GNT(GNT), .BUS_OUT(BUS_OUT), .BUS_OE(BUS_OE),
      .BUS_STB(BUS_STB), .DONE(DONE), .TIMEOUT_ERR(TIMEOUT_ERR)
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Advance one edge; outputs are read and inputs changed 2ns later.
   task automatic tick();
      @(posedge CLK);
      #2;
   endtask

   function automatic int oh2idx(input logic [NREQ-1:0] v);
      int r = -1;
      for (int i = 0; i < NREQ; i++) if (v[i]) r = i;
      return r;
   endfunction

   logic [4:0] t2_stb  = 5'b01111;
   logic [4:0] t2_done = 5'b01000;
   logic [4:0] t2_oe   = 5'b01111;
   logic [6:0] t4_vld  = 7'b0010101;
   logic [6:0] t4_done = 7'b0010000;

   initial begin
      int grants [8];
      int ng, owner, lowrun, nstb, seen;
      logic [NREQ-1:0] prev_gnt;
      logic prev_oe;

      RESET = 1'b1; REQ = '0; LEN = '0; DIN = '0; VALID = '0;
      #1;
      chk("rst_gnt", GNT, 0);
      chk("rst_oe", BUS_OE, 0);
      chk("rst_stb", BUS_STB, 0);
      chk("rst_bus", BUS_OUT, 0);
      chk("rst_terr", TIMEOUT_ERR, 0);
      tick(); tick();
      RESET = 1'b0;
      tick();

      // Requester 0, four words A0..A3 with VALID held high.
      REQ = 4'b0001; LEN[3:0] = 4'd3; VALID = 4'b0001; DIN[31:0] = 32'hA0;
      tick();
      chk("t2_gnt", GNT, 4'b0001);
      chk("t2_rdy", READY, 4'b0001);
      chk("t2_oe", BUS_OE, 1);
      REQ = '0;
      for (int j = 0; j < 5; j++) begin
         tick();
         chk("t2_stb", BUS_STB, t2_stb[j]);
         chk("t2_bus", BUS_OUT, 32'hA0 + ((j < 4) ? j : 3));
         chk("t2_done", DONE, t2_done[j]);
         chk("t2_oe_seq", BUS_OE, t2_oe[j]);
         DIN[31:0] = 32'hA1 + j;
      end
      VALID = '0;

      // Requester 1, three words with VALID toggling; REQ dropped after first word.
      REQ = 4'b0010; LEN[7:4] = 4'd2;
      tick();
      chk("t4_gnt", GNT, 4'b0010);
      nstb = 0;
      for (int j = 0; j < 7; j++) begin
         VALID[1] = t4_vld[j];
         DIN[63:32] = 32'hC0 + nstb;
         tick();
         if (j == 0) REQ = '0;
         if (j == 2) chk("t4_gnt_held", GNT, 4'b0010);
         chk("t4_stb", BUS_STB, t4_vld[j] & (j < 5));
         chk("t4_done", DONE, t4_done[j]);
         if (BUS_STB) begin
            chk("t4_bus", BUS_OUT, 32'hC0 + nstb);
            nstb++;
         end
      end
      chk("t4_nstb", nstb, 3);
      VALID = '0;

      // Reset in the middle of requester 2's burst.
      REQ = 4'b0100; LEN[11:8] = 4'd7; VALID = 4'b0100; DIN[95:64] = 32'hD0;
      tick();
      chk("rm_gnt", GNT, 4'b0100);
      REQ = '0;
      tick(); tick();
      chk("rm_stb_pre", BUS_STB, 1);
      #1 RESET = 1'b1;
      #1;
      chk("rm_gnt0", GNT, 0);
      chk("rm_rdy0", READY, 0);
      chk("rm_oe0", BUS_OE, 0);
      chk("rm_stb0", BUS_STB, 0);
      chk("rm_bus0", BUS_OUT, 0);
      chk("rm_done0", DONE, 0);
      tick();
      chk("rm_done_hold", DONE, 0);
      RESET = 1'b0; VALID = '0;
      tick();

      // All four requesting single-word bursts: order 0,1,2,3,0.
      LEN = '0; VALID = 4'b1111; REQ = 4'b1111;
      for (int i = 0; i < NREQ; i++) DIN[i*DW +: DW] = 32'hB0 + i;
      ng = 0; owner = -1; lowrun = 0; prev_gnt = '0; prev_oe = 1'b0;
      for (int j = 0; j < 20; j++) begin
         tick();
         if (GNT != 0 && prev_gnt == 0 && ng < 8) begin
            grants[ng] = oh2idx(GNT);
            owner = grants[ng];
            ng++;
         end
         if (BUS_STB) chk("rr_bus", BUS_OUT, 32'hB0 + owner);
         if (!BUS_OE) lowrun++;
         if (BUS_OE && !prev_oe) begin
            if (ng > 1) chk("rr_gap", lowrun >= 1, 1);
            lowrun = 0;
         end
         prev_gnt = GNT;
         prev_oe = BUS_OE;
      end
      chk("rr_cnt", ng >= 5, 1);
      for (int k = 0; k < 5; k++) chk("rr_order", grants[k], k % NREQ);
      REQ = '0;
      for (int j = 0; j < 6; j++) tick();
      chk("rr_idle_oe", BUS_OE, 0);

      // Request arriving during TURN of requester 0 goes to requester 2.
      REQ = 4'b0001; LEN[3:0] = 4'd1; LEN[11:8] = 4'd0; VALID = 4'b0001;
      seen = 0;
      for (int j = 0; j < 10 && !seen; j++) begin
         tick();
         if (DONE) seen = 1;
      end
      chk("tn_done_seen", seen, 1);
      REQ = 4'b0101;
      tick();
      chk("tn_idle_gnt", GNT, 0);
      chk("tn_idle_oe", BUS_OE, 0);
      tick();
      chk("tn_gnt", GNT, 4'b0100);
      REQ = '0; VALID = 4'b0100;
      tick(); tick(); tick();
      VALID = '0;
      chk("tn_end_oe", BUS_OE, 0);

`ifdef CONN_ARB_TIMEOUT_EN
      // Stall on requester 2 with no VALID: abort after 4 stall cycles.
      REQ = 4'b0100; LEN[11:8] = 4'd3; VALID = '0;
      tick();
      chk("to_gnt", GNT, 4'b0100);
      for (int j = 0; j < 3; j++) tick();
      chk("to_pre", GNT, 4'b0100);
      chk("to_pre_err", TIMEOUT_ERR, 0);
      tick();
      chk("to_abort_gnt", GNT, 0);
      chk("to_err", TIMEOUT_ERR, 1);
      chk("to_nodone", DONE, 0);
      chk("to_nostb", BUS_STB, 0);
      REQ = 4'b1100; LEN[15:12] = 4'd0; VALID = 4'b1000;
      tick();
      chk("to_idle_oe", BUS_OE, 0);
      tick();
      chk("to_next", GNT, 4'b1000);
      REQ = '0;
      tick(); tick(); tick();
      chk("to_sticky", TIMEOUT_ERR, 1);
`else
      chk("terr_tied", TIMEOUT_ERR, 0);
`endif

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end
endmodule
